// File: rtl/frv_wb_mem_pkg.sv
// Shared types for the imem/dmem Wishbone responder.
//   state_e : access sequencer states
//   grant_e : which initiator port owns the current SRAM access
package frv_wb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IMEM = 1'b0,
    GNT_DMEM = 1'b1
  } grant_e;

  // Wait counter covers the full 0..15 wait-state range.
  localparam int CNT_W = $clog2(16);

  // Bit positions inside the packed request vector.
  localparam int REQ_IMEM = 0;
  localparam int REQ_DMEM = 1;

endpackage

// File: rtl/frv_wb_arb2.sv
// 2-way round-robin arbiter between the imem and dmem request lines.
// Purely combinational; the caller owns the last-grant register.
//   req  in  2  request vector (bit REQ_IMEM, bit REQ_DMEM)
//   en   in  1  arbitration allowed this cycle
//   last in     port granted most recently
//   gnt  out    winning port (equals last when not enabled or nobody requests)
module frv_wb_arb2
  import frv_wb_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       en,
  input  grant_e     last,
  output grant_e     gnt
);

  always_comb begin
    gnt = last;
    if (en) begin
      if (req[REQ_IMEM] && req[REQ_DMEM]) begin
        // Tie: hand the SRAM to whichever port did not have it last.
        gnt = (last == GNT_IMEM) ? GNT_DMEM : GNT_IMEM;
      end else if (req[REQ_DMEM]) begin
        gnt = GNT_DMEM;
      end else if (req[REQ_IMEM]) begin
        gnt = GNT_IMEM;
      end
    end
  end

endmodule

// File: rtl/frv_wb_mem_resp.sv
// Wishbone classic responder serving the core's imem (read-only) and dmem
// (read/write) ports from one shared single-port SRAM macro.
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wb_imem_*               imem initiator: cyc/stb/adr in, dat/ack out
//   wb_dmem_*               dmem initiator: cyc/stb/we/be/adr/dat in, dat/ack out
//   sram_*                  SRAM macro: ce/we/be/adr/dat out, dat in (1 cycle after ce)
// Parameters: ADR_W word-address width, WAIT extra wait cycles before ack.
//
//   state | meaning
//   IDLE  | arbitrate; on a grant register the SRAM command
//   MEM   | sram_ce_o high for this single cycle
//   WAIT  | count down the configured wait states
//   ACK   | capture read data and pulse ack (unless the initiator aborted)
module frv_wb_mem_resp #(
  parameter int ADR_W = 10,
  parameter int WAIT  = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wb_imem_cyc_i,
  input  logic             wb_imem_stb_i,
  input  logic [31:0]      wb_imem_adr_i,
  output logic [31:0]      wb_imem_dat_o,
  output logic             wb_imem_ack_o,
  input  logic             wb_dmem_cyc_i,
  input  logic             wb_dmem_stb_i,
  input  logic             wb_dmem_we_i,
  input  logic [3:0]       wb_dmem_be_i,
  input  logic [31:0]      wb_dmem_adr_i,
  input  logic [31:0]      wb_dmem_dat_i,
  output logic [31:0]      wb_dmem_dat_o,
  output logic             wb_dmem_ack_o,
  output logic             sram_ce_o,
  output logic             sram_we_o,
  output logic [3:0]       sram_be_o,
  output logic [ADR_W-1:0] sram_adr_o,
  output logic [31:0]      sram_dat_o,
  input  logic [31:0]      sram_dat_i
);

  import frv_wb_mem_pkg::*;

  // Counter is loaded with WAIT-1 so that exactly WAIT cycles are spent in WAIT.
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT == 0) ? '0 : CNT_W'(WAIT - 1);

  state_e           state;
  state_e           state_nxt;
  grant_e           last_grant;
  grant_e           arb_gnt;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic [1:0]       req;
  logic             arb_en;
  logic             gnt_cyc;

  // Byte offset and high address bits alias onto the same SRAM word.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_imem_adr_i[31:ADR_W+2], wb_imem_adr_i[1:0],
                             wb_dmem_adr_i[31:ADR_W+2], wb_dmem_adr_i[1:0]};

  assign req[REQ_IMEM] = wb_imem_cyc_i & wb_imem_stb_i;
  assign req[REQ_DMEM] = wb_dmem_cyc_i & wb_dmem_stb_i;
  assign arb_en        = (state == frv_wb_mem_pkg::IDLE);

  // last_grant doubles as the held grant for the access in flight.
  assign gnt_cyc = (last_grant == GNT_DMEM) ? wb_dmem_cyc_i : wb_imem_cyc_i;

  frv_wb_arb2 u_arb (
    .req  (req),
    .en   (arb_en),
    .last (last_grant),
    .gnt  (arb_gnt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= frv_wb_mem_pkg::IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      frv_wb_mem_pkg::IDLE: begin
        if (|req) state_nxt = frv_wb_mem_pkg::MEM;
      end
      frv_wb_mem_pkg::MEM: begin
        // The SRAM command is issued this cycle, so an abort here still commits.
        if (!gnt_cyc)       state_nxt = frv_wb_mem_pkg::IDLE;
        else if (WAIT != 0) state_nxt = frv_wb_mem_pkg::WAIT;
        else                state_nxt = frv_wb_mem_pkg::ACK;
      end
      frv_wb_mem_pkg::WAIT: begin
        if (!gnt_cyc)       state_nxt = frv_wb_mem_pkg::IDLE;
        else if (cnt == '0) state_nxt = frv_wb_mem_pkg::ACK;
      end
      frv_wb_mem_pkg::ACK: begin
        state_nxt = frv_wb_mem_pkg::IDLE;
      end
      default: state_nxt = frv_wb_mem_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant    <= GNT_IMEM;
      cnt           <= '0;
      wr_q          <= 1'b0;
      sram_ce_o     <= 1'b0;
      sram_we_o     <= 1'b0;
      sram_be_o     <= 4'b0;
      sram_adr_o    <= '0;
      sram_dat_o    <= 32'b0;
      wb_imem_dat_o <= 32'b0;
      wb_imem_ack_o <= 1'b0;
      wb_dmem_dat_o <= 32'b0;
      wb_dmem_ack_o <= 1'b0;
    end else begin
      sram_ce_o     <= 1'b0;
      sram_we_o     <= 1'b0;
      sram_be_o     <= 4'b0;
      wb_imem_ack_o <= 1'b0;
      wb_dmem_ack_o <= 1'b0;

      if (state == frv_wb_mem_pkg::MEM) begin
        cnt <= WAIT_LOAD;
      end else if (state == frv_wb_mem_pkg::WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        cnt <= '0;
      end

      if (state == frv_wb_mem_pkg::IDLE && |req) begin
        last_grant <= arb_gnt;
        sram_ce_o  <= 1'b1;
        if (arb_gnt == GNT_DMEM) begin
          wr_q       <= wb_dmem_we_i;
          sram_we_o  <= wb_dmem_we_i;
          sram_be_o  <= wb_dmem_we_i ? wb_dmem_be_i : 4'b0;
          sram_adr_o <= wb_dmem_adr_i[ADR_W+1:2];
          sram_dat_o <= wb_dmem_dat_i;
        end else begin
          wr_q       <= 1'b0;
          sram_adr_o <= wb_imem_adr_i[ADR_W+1:2];
        end
      end

      if (state == frv_wb_mem_pkg::ACK && gnt_cyc) begin
        if (last_grant == GNT_DMEM) begin
          wb_dmem_ack_o <= 1'b1;
          if (!wr_q) wb_dmem_dat_o <= sram_dat_i;
        end else begin
          wb_imem_ack_o <= 1'b1;
          wb_imem_dat_o <= sram_dat_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_frv_wb_mem_resp.sv
module tb_frv_wb_mem_resp;

  logic        clk;
  logic        rst;
  logic        imem_cyc, imem_stb;
  logic [31:0] imem_adr;
  logic        dmem_cyc, dmem_stb, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_adr, dmem_wdat;

  logic [31:0] imem_dat0, dmem_dat0, sdat0, rdat0;
  logic        imem_ack0, dmem_ack0, ce0, we0;
  logic [3:0]  be0;
  logic [9:0]  adr0;

  logic [31:0] imem_dat3, dmem_dat3, sdat3, rdat3;
  logic        imem_ack3, dmem_ack3, ce3, we3;
  logic [3:0]  be3;
  logic [9:0]  adr3;

  logic [31:0] mem0 [1024];
  logic [31:0] mem3 [1024];

  int n_cmp = 0;
  int n_err = 0;

  frv_wb_mem_resp #(.ADR_W(10), .WAIT(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .wb_imem_cyc_i(imem_cyc), .wb_imem_stb_i(imem_stb), .wb_imem_adr_i(imem_adr),
    .wb_imem_dat_o(imem_dat0), .wb_imem_ack_o(imem_ack0),
    .wb_dmem_cyc_i(dmem_cyc), .wb_dmem_stb_i(dmem_stb), .wb_dmem_we_i(dmem_we),
    .wb_dmem_be_i(dmem_be), .wb_dmem_adr_i(dmem_adr), .wb_dmem_dat_i(dmem_wdat),
    .wb_dmem_dat_o(dmem_dat0), .wb_dmem_ack_o(dmem_ack0),
    .sram_ce_o(ce0), .sram_we_o(we0), .sram_be_o(be0), .sram_adr_o(adr0),
    .sram_dat_o(sdat0), .sram_dat_i(rdat0)
  );

  frv_wb_mem_resp #(.ADR_W(10), .WAIT(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .wb_imem_cyc_i(imem_cyc), .wb_imem_stb_i(imem_stb), .wb_imem_adr_i(imem_adr),
    .wb_imem_dat_o(imem_dat3), .wb_imem_ack_o(imem_ack3),
    .wb_dmem_cyc_i(dmem_cyc), .wb_dmem_stb_i(dmem_stb), .wb_dmem_we_i(dmem_we),
    .wb_dmem_be_i(dmem_be), .wb_dmem_adr_i(dmem_adr), .wb_dmem_dat_i(dmem_wdat),
    .wb_dmem_dat_o(dmem_dat3), .wb_dmem_ack_o(dmem_ack3),
    .sram_ce_o(ce3), .sram_we_o(we3), .sram_be_o(be3), .sram_adr_o(adr3),
    .sram_dat_o(sdat3), .sram_dat_i(rdat3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: byte-masked write, registered read data held until next read.
  always @(posedge clk) begin
    if (ce0) begin
      if (we0) begin
        for (int b = 0; b < 4; b++)
          if (be0[b]) mem0[adr0][b*8 +: 8] = sdat0[b*8 +: 8];
      end else begin
        rdat0 <= mem0[adr0];
      end
    end
  end

  always @(posedge clk) begin
    if (ce3) begin
      if (we3) begin
        for (int b = 0; b < 4; b++)
          if (be3[b]) mem3[adr3][b*8 +: 8] = sdat3[b*8 +: 8];
      end else begin
        rdat3 <= mem3[adr3];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one dmem access; lat counts edges from the sampling edge to the ack edge.
  task automatic dmem_access(input bit sel3, input bit we, input logic [3:0] be,
                             input logic [31:0] adr, input logic [31:0] wdat,
                             output logic [31:0] rdat, output int lat, output int ce_cnt);
    dmem_cyc = 1'b1; dmem_stb = 1'b1; dmem_we = we; dmem_be = be;
    dmem_adr = adr; dmem_wdat = wdat;
    lat = -1; ce_cnt = 0; rdat = 32'h0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (sel3 ? ce3 : ce0) ce_cnt++;
      if (sel3 ? dmem_ack3 : dmem_ack0) begin
        lat  = n - 1;
        rdat = sel3 ? dmem_dat3 : dmem_dat0;
        break;
      end
    end
    dmem_cyc = 1'b0; dmem_stb = 1'b0; dmem_we = 1'b0; dmem_be = 4'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({imem_ack0, dmem_ack0} !== 2'b00) begin
      n_err++; $display("FAIL reset_ack: got %b want 00", {imem_ack0, dmem_ack0});
    end
    n_cmp++;
    if ({imem_dat0, dmem_dat0} !== 64'h0) begin
      n_err++; $display("FAIL reset_dat: got %h want 0", {imem_dat0, dmem_dat0});
    end
    n_cmp++;
    if ({ce0, we0, be0} !== 6'b0) begin
      n_err++; $display("FAIL reset_sram_ctl: got %b want 0", {ce0, we0, be0});
    end
    n_cmp++;
    if ({adr0, sdat0} !== 42'h0) begin
      n_err++; $display("FAIL reset_sram_adr_dat: got %h want 0", {adr0, sdat0});
    end
    n_cmp++;
    if ({imem_ack3, dmem_ack3, ce3, we3, be3, adr3, imem_dat3, dmem_dat3, sdat3} !== 114'h0) begin
      n_err++; $display("FAIL reset_wait3_outputs: got nonzero want 0");
    end
  endtask

  task automatic test_imem_read();
    mem0[10'h020] = 32'hDEAD_BEEF;
    imem_cyc = 1'b1; imem_stb = 1'b1; imem_adr = 32'h0000_0080;
    tick();
    n_cmp++;
    if ({ce0, we0, adr0} !== {1'b1, 1'b0, 10'h020}) begin
      n_err++; $display("FAIL imem_cmd: got ce/we/adr %b/%b/%h want 1/0/020", ce0, we0, adr0);
    end
    tick();
    n_cmp++;
    if ({ce0, imem_ack0} !== 2'b00) begin
      n_err++; $display("FAIL imem_early: got ce/ack %b want 00", {ce0, imem_ack0});
    end
    tick();
    n_cmp++;
    if ({imem_ack0, dmem_ack0} !== 2'b10) begin
      n_err++; $display("FAIL imem_ack: got %b want 10", {imem_ack0, dmem_ack0});
    end
    n_cmp++;
    if (imem_dat0 !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL imem_dat: got %h want deadbeef", imem_dat0);
    end
    imem_cyc = 1'b0; imem_stb = 1'b0;
    tick();
    n_cmp++;
    if (imem_ack0 !== 1'b0) begin
      n_err++; $display("FAIL imem_ack_width: got %b want 0", imem_ack0);
    end
  endtask

  task automatic test_dmem_write_read();
    logic [31:0] rd;
    int lat, cec;
    mem0[10'h041] = 32'hAABB_CCDD;
    dmem_access(1'b0, 1'b1, 4'b0110, 32'h0000_0104, 32'h1122_3344, rd, lat, cec);
    n_cmp++;
    if (lat !== 2 || cec !== 1) begin
      n_err++; $display("FAIL wr_lat: got lat %0d ce %0d want 2 1", lat, cec);
    end
    n_cmp++;
    if (mem0[10'h041] !== 32'hAA22_33DD) begin
      n_err++; $display("FAIL wr_bytes: got %h want aa2233dd", mem0[10'h041]);
    end
    n_cmp++;
    if (dmem_dat0 !== 32'h0) begin
      n_err++; $display("FAIL wr_dat_hold: got %h want 0", dmem_dat0);
    end
    dmem_access(1'b0, 1'b0, 4'b0, 32'h0000_0104, 32'h0, rd, lat, cec);
    n_cmp++;
    if (rd !== 32'hAA22_33DD || lat !== 2) begin
      n_err++; $display("FAIL rd_back: got %h lat %0d want aa2233dd lat 2", rd, lat);
    end
    n_cmp++;
    if (imem_dat0 !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL imem_dat_untouched: got %h want deadbeef", imem_dat0);
    end
    dmem_access(1'b0, 1'b1, 4'b0000, 32'h0000_0104, 32'hFFFF_FFFF, rd, lat, cec);
    n_cmp++;
    if (lat !== 2 || mem0[10'h041] !== 32'hAA22_33DD) begin
      n_err++; $display("FAIL be0_write: got lat %0d mem %h want 2 aa2233dd", lat, mem0[10'h041]);
    end
    n_cmp++;
    if (dmem_dat0 !== 32'hAA22_33DD) begin
      n_err++; $display("FAIL be0_dat_hold: got %h want aa2233dd", dmem_dat0);
    end
    mem0[10'h042] = 32'h0BAD_CAFE;
    dmem_access(1'b0, 1'b0, 4'b0, 32'hFFFF_F10B, 32'h0, rd, lat, cec);
    n_cmp++;
    if (rd !== 32'h0BAD_CAFE || lat !== 2) begin
      n_err++; $display("FAIL alias_rd: got %h lat %0d want 0badcafe lat 2", rd, lat);
    end
  endtask

  task automatic test_tie();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    tick();
    mem0[10'h010] = 32'h1111_0000;
    mem0[10'h011] = 32'h2222_0000;
    imem_cyc = 1'b1; imem_stb = 1'b1; imem_adr = 32'h40;
    dmem_cyc = 1'b1; dmem_stb = 1'b1; dmem_we = 1'b0; dmem_adr = 32'h44;
    tick();
    n_cmp++;
    if (adr0 !== 10'h011) begin
      n_err++; $display("FAIL tie_first_gnt: got adr %h want 011", adr0);
    end
    tick();
    tick();
    n_cmp++;
    if ({imem_ack0, dmem_ack0, dmem_dat0} !== {2'b01, 32'h2222_0000}) begin
      n_err++; $display("FAIL tie_dmem_ack: got acks %b dat %h want 01 22220000",
                        {imem_ack0, dmem_ack0}, dmem_dat0);
    end
    tick();
    n_cmp++;
    if ({imem_ack0, dmem_ack0, ce0, adr0} !== {3'b001, 10'h010}) begin
      n_err++; $display("FAIL tie_second_gnt: got acks %b ce %b adr %h want 00 1 010",
                        {imem_ack0, dmem_ack0}, ce0, adr0);
    end
    dmem_cyc = 1'b0; dmem_stb = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({imem_ack0, dmem_ack0, imem_dat0} !== {2'b10, 32'h1111_0000}) begin
      n_err++; $display("FAIL tie_imem_ack: got acks %b dat %h want 10 11110000",
                        {imem_ack0, dmem_ack0}, imem_dat0);
    end
    imem_cyc = 1'b0; imem_stb = 1'b0;
    tick();
    // last grant is imem now: a fresh tie goes to dmem
    imem_cyc = 1'b1; imem_stb = 1'b1;
    dmem_cyc = 1'b1; dmem_stb = 1'b1;
    tick();
    n_cmp++;
    if (adr0 !== 10'h011) begin
      n_err++; $display("FAIL tie_rr_dmem: got adr %h want 011", adr0);
    end
    imem_cyc = 1'b0; imem_stb = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({imem_ack0, dmem_ack0} !== 2'b01) begin
      n_err++; $display("FAIL tie_rr_dmem_ack: got %b want 01", {imem_ack0, dmem_ack0});
    end
    dmem_cyc = 1'b0; dmem_stb = 1'b0;
    tick();
    // last grant is dmem now: a fresh tie goes to imem
    imem_cyc = 1'b1; imem_stb = 1'b1;
    dmem_cyc = 1'b1; dmem_stb = 1'b1;
    tick();
    n_cmp++;
    if (adr0 !== 10'h010) begin
      n_err++; $display("FAIL tie_rr_imem: got adr %h want 010", adr0);
    end
    dmem_cyc = 1'b0; dmem_stb = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({imem_ack0, dmem_ack0} !== 2'b10) begin
      n_err++; $display("FAIL tie_rr_imem_ack: got %b want 10", {imem_ack0, dmem_ack0});
    end
    imem_cyc = 1'b0; imem_stb = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    int lat, cec;
    repeat (8) tick();
    mem3[10'h030] = 32'hCAFE_F00D;
    dmem_access(1'b1, 1'b0, 4'b0, 32'h0000_00C0, 32'h0, rd, lat, cec);
    n_cmp++;
    if (lat !== 5 || cec !== 1) begin
      n_err++; $display("FAIL wait3_lat: got lat %0d ce %0d want 5 1", lat, cec);
    end
    n_cmp++;
    if (rd !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL wait3_dat: got %h want cafef00d", rd);
    end
    tick();
    n_cmp++;
    if (dmem_ack3 !== 1'b0) begin
      n_err++; $display("FAIL wait3_ack_width: got %b want 0", dmem_ack3);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int lat, cec, acks;
    mem0[10'h050] = 32'h0;
    dmem_cyc = 1'b1; dmem_stb = 1'b1; dmem_we = 1'b1; dmem_be = 4'hF;
    dmem_adr = 32'h140; dmem_wdat = 32'h5A5A_5A5A;
    tick();
    tick();
    dmem_cyc = 1'b0; dmem_stb = 1'b0; dmem_we = 1'b0; dmem_be = 4'h0;
    acks = 0;
    repeat (4) begin
      tick();
      if (dmem_ack0) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_err++; $display("FAIL abort_no_ack: got %0d acks want 0", acks);
    end
    n_cmp++;
    if (mem0[10'h050] !== 32'h5A5A_5A5A) begin
      n_err++; $display("FAIL abort_commit: got %h want 5a5a5a5a", mem0[10'h050]);
    end
    dmem_access(1'b0, 1'b0, 4'b0, 32'h140, 32'h0, rd, lat, cec);
    n_cmp++;
    if (rd !== 32'h5A5A_5A5A || lat !== 2) begin
      n_err++; $display("FAIL abort_then_rd: got %h lat %0d want 5a5a5a5a lat 2", rd, lat);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    int lat, cec, acks;
    dmem_cyc = 1'b1; dmem_stb = 1'b1; dmem_we = 1'b0; dmem_adr = 32'hC0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({dmem_ack3, imem_ack3, ce3, we3, be3, adr3} !== 18'h0) begin
      n_err++; $display("FAIL rst_mid_ctl: got %h want 0", {dmem_ack3, imem_ack3, ce3, we3, be3, adr3});
    end
    n_cmp++;
    if (dmem_dat3 !== 32'h0) begin
      n_err++; $display("FAIL rst_mid_dat: got %h want 0", dmem_dat3);
    end
    dmem_cyc = 1'b0; dmem_stb = 1'b0;
    @(negedge clk) rst = 1'b0;
    acks = 0;
    repeat (8) begin
      tick();
      if (dmem_ack3) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_err++; $display("FAIL rst_mid_no_ack: got %0d acks want 0", acks);
    end
    dmem_access(1'b1, 1'b0, 4'b0, 32'hC0, 32'h0, rd, lat, cec);
    n_cmp++;
    if (rd !== 32'hCAFE_F00D || lat !== 5) begin
      n_err++; $display("FAIL rst_mid_recover: got %h lat %0d want cafef00d lat 5", rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:1] pattern;
    pattern = '0;
    dmem_cyc = 1'b1; dmem_stb = 1'b1; dmem_we = 1'b0; dmem_adr = 32'h104;
    for (int n = 1; n <= 7; n++) begin
      tick();
      pattern[n] = dmem_ack0;
      if (n == 6) begin
        dmem_cyc = 1'b0; dmem_stb = 1'b0;
      end
    end
    n_cmp++;
    if (pattern !== 7'b0100100) begin
      n_err++; $display("FAIL b2b_ack_pattern: got %b want 0100100", pattern);
    end
    n_cmp++;
    if (dmem_dat0 !== 32'hAA22_33DD) begin
      n_err++; $display("FAIL b2b_dat: got %h want aa2233dd", dmem_dat0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    imem_cyc = 1'b0; imem_stb = 1'b0; imem_adr = 32'h0;
    dmem_cyc = 1'b0; dmem_stb = 1'b0; dmem_we = 1'b0; dmem_be = 4'h0;
    dmem_adr = 32'h0; dmem_wdat = 32'h0;
    #3;
    test_reset();
    @(negedge clk) rst = 1'b0;
    tick();
    test_imem_read();
    test_dmem_write_read();
    test_tie();
    test_wait_states();
    test_abort();
    test_reset_mid_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
